// File: rtl/memu.sv
// rtl/memu.sv - memory-access/load-align stage between execute and write-back
module memu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH+ADDR_WIDTH+3:0] exe_to_mem_bus,
    input  logic                             exe_to_mem_valid,
    output logic                             mem_to_exe_ready,
    input  logic [DATA_WIDTH-1:0]            load_data,
    output logic [DATA_WIDTH+ADDR_WIDTH:0]   mem_to_wb_bus,
    output logic                             mem_to_wb_valid,
    input  logic                             wb_to_mem_ready,
    output logic                             mem_fwd_valid,
    output logic [ADDR_WIDTH-1:0]            mem_fwd_addr,
    output logic [DATA_WIDTH-1:0]            mem_fwd_data,
    output logic                             mem_misalign
);

    localparam int BUS_W = DATA_WIDTH + ADDR_WIDTH + 4;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    logic                  valid_q;
    logic                  first_cyc_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  regw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [2:0]            ld_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  misalign;
    logic                  wb_regw;

    assign mem_to_exe_ready = ~valid_q | wb_to_mem_ready;
    assign accept           = exe_to_mem_valid & mem_to_exe_ready;

    // Pipeline register: capture on accept, drop on consume, and latch the
    // SRAM word one cycle after acceptance since load_data is only valid then.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            first_cyc_q <= 1'b0;
            hold_q      <= '0;
            regw_q      <= 1'b0;
            addr_q      <= '0;
            alu_q       <= '0;
            ld_q        <= '0;
        end else begin
            if (first_cyc_q) begin
                hold_q <= load_data;
            end
            if (accept) begin
                valid_q     <= 1'b1;
                first_cyc_q <= 1'b1;
                regw_q      <= exe_to_mem_bus[BUS_W-1];
                addr_q      <= exe_to_mem_bus[BUS_W-2 -: ADDR_WIDTH];
                alu_q       <= exe_to_mem_bus[DATA_WIDTH+2 -: DATA_WIDTH];
                ld_q        <= exe_to_mem_bus[2:0];
            end else begin
                first_cyc_q <= 1'b0;
                if (wb_to_mem_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    // Lane select, extension and misalignment detection for the held instruction.
    always_comb begin
        word     = first_cyc_q ? load_data : hold_q;
        byte_v   = word[7:0];
        half_v   = alu_q[1] ? word[DATA_WIDTH-1:16] : word[15:0];
        wb_data  = alu_q;
        misalign = 1'b0;
        case (alu_q[1:0])
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (ld_q)
            LD_LB:  wb_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            LD_LBU: wb_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            LD_LH: begin
                wb_data  = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
                misalign = alu_q[0];
            end
            LD_LHU: begin
                wb_data  = {{(DATA_WIDTH-16){1'b0}}, half_v};
                misalign = alu_q[0];
            end
            LD_LW: begin
                wb_data  = word;
                misalign = (alu_q[1:0] != 2'd0);
            end
            default: wb_data = alu_q;
        endcase
        wb_regw = regw_q & ~misalign;
    end

    assign mem_to_wb_valid = valid_q;
    assign mem_to_wb_bus   = {wb_regw, addr_q, wb_data};
    assign mem_misalign    = valid_q & misalign;
    assign mem_fwd_valid   = valid_q & wb_regw & (addr_q != '0);
    assign mem_fwd_addr    = addr_q;
    assign mem_fwd_data    = wb_data;

endmodule

// File: tb/tb_memu.sv
// tb/tb_memu.sv - directed self-checking bench for memu
module tb_memu;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW+AW+3:0] exe_to_mem_bus;
    logic           exe_to_mem_valid;
    logic           mem_to_exe_ready;
    logic [DW-1:0]  load_data;
    logic [DW+AW:0] mem_to_wb_bus;
    logic           mem_to_wb_valid;
    logic           wb_to_mem_ready;
    logic           mem_fwd_valid;
    logic [AW-1:0]  mem_fwd_addr;
    logic [DW-1:0]  mem_fwd_data;
    logic           mem_misalign;

    int n_cmp = 0;
    int n_err = 0;

    memu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .exe_to_mem_valid (exe_to_mem_valid),
        .mem_to_exe_ready (mem_to_exe_ready),
        .load_data        (load_data),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .wb_to_mem_ready  (wb_to_mem_ready),
        .mem_fwd_valid    (mem_fwd_valid),
        .mem_fwd_addr     (mem_fwd_addr),
        .mem_fwd_data     (mem_fwd_data),
        .mem_misalign     (mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW+AW+3:0] mk(input logic w, input logic [AW-1:0] a,
                                            input logic [DW-1:0] r, input logic [2:0] ld);
        return {w, a, r, ld};
    endfunction

    function automatic logic [DW+AW:0] wb(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {w, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one load with wb_ready=1, present the SRAM word, check the result, let it drain.
    task automatic do_load(input string tag, input logic [2:0] ld, input logic [DW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] exp);
        wb_to_mem_ready  = 1'b1;
        exe_to_mem_bus   = mk(1'b1, 5'd8, addr, ld);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        load_data        = data;
        #1;
        chk({tag, "_bus"}, mem_to_wb_bus, wb(1'b1, 5'd8, exp));
        chk({tag, "_mis"}, mem_misalign, 1'b0);
        tick();
        chk({tag, "_drain"}, mem_to_wb_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        exe_to_mem_bus = '0;
        exe_to_mem_valid = 1'b0;
        load_data = '0;
        wb_to_mem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", mem_to_wb_valid, 1'b0);
        chk("rst_bus", mem_to_wb_bus, '0);
        chk("rst_fwd", mem_fwd_valid, 1'b0);
        chk("rst_mis", mem_misalign, 1'b0);
        chk("rst_ready", mem_to_exe_ready, 1'b1);

        // back-to-back non-loads
        exe_to_mem_bus   = mk(1'b1, 5'd5, 32'h1234_5678, 3'd0);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_bus   = mk(1'b1, 5'd6, 32'h1, 3'd0);
        #1;
        chk("add1_valid", mem_to_wb_valid, 1'b1);
        chk("add1_bus", mem_to_wb_bus, wb(1'b1, 5'd5, 32'h1234_5678));
        chk("add1_fwdv", mem_fwd_valid, 1'b1);
        chk("add1_fwda", mem_fwd_addr, 5'd5);
        chk("add1_fwdd", mem_fwd_data, 32'h1234_5678);
        tick();
        exe_to_mem_valid = 1'b0;
        #1;
        chk("add2_valid", mem_to_wb_valid, 1'b1);
        chk("add2_bus", mem_to_wb_bus, wb(1'b1, 5'd6, 32'h1));
        chk("add2_fwdv", mem_fwd_valid, 1'b1);
        tick();
        chk("add_drain", mem_to_wb_valid, 1'b0);

        // byte / halfword extraction
        do_load("lb3",  3'd1, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu3", 3'd4, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
        do_load("lb1",  3'd1, 32'h1001, 32'h0000_7F00, 32'h0000_007F);
        do_load("lh2",  3'd2, 32'h1002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu0", 3'd5, 32'h1000, 32'h8001_1234, 32'h0000_1234);
        do_load("lw0",  3'd3, 32'h1000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // LW under a 3-cycle write-back stall
        wb_to_mem_ready  = 1'b0;
        exe_to_mem_bus   = mk(1'b1, 5'd9, 32'h2000, 3'd3);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        load_data        = 32'hDEAD_BEEF;
        #1;
        chk("stall0_bus", mem_to_wb_bus, wb(1'b1, 5'd9, 32'hDEAD_BEEF));
        chk("stall0_rdy", mem_to_exe_ready, 1'b0);
        for (int i = 1; i < 3; i++) begin
            tick();
            load_data        = 32'h0;
            exe_to_mem_bus   = mk(1'b1, 5'd10, 32'h5555, 3'd0);
            exe_to_mem_valid = 1'b1;
            #1;
            chk($sformatf("stall%0d_bus", i), mem_to_wb_bus, wb(1'b1, 5'd9, 32'hDEAD_BEEF));
            chk($sformatf("stall%0d_rdy", i), mem_to_exe_ready, 1'b0);
            chk($sformatf("stall%0d_val", i), mem_to_wb_valid, 1'b1);
        end
        exe_to_mem_valid = 1'b0;
        wb_to_mem_ready  = 1'b1;
        #1;
        chk("release_rdy", mem_to_exe_ready, 1'b1);
        tick();
        chk("release_drain", mem_to_wb_valid, 1'b0);

        // misaligned LW to x7
        exe_to_mem_bus   = mk(1'b1, 5'd7, 32'h0000_0102, 3'd3);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        load_data        = 32'h1357_9BDF;
        #1;
        chk("mis_flag", mem_misalign, 1'b1);
        chk("mis_bus", mem_to_wb_bus, wb(1'b0, 5'd7, 32'h1357_9BDF));
        chk("mis_fwd", mem_fwd_valid, 1'b0);
        tick();

        // non-load to x0 must not forward
        exe_to_mem_bus   = mk(1'b1, 5'd0, 32'h77, 3'd0);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        #1;
        chk("x0_valid", mem_to_wb_valid, 1'b1);
        chk("x0_fwd", mem_fwd_valid, 1'b0);
        tick();

        // reset while a stalled load is held
        wb_to_mem_ready  = 1'b0;
        exe_to_mem_bus   = mk(1'b1, 5'd3, 32'h4, 3'd3);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        load_data        = 32'h55;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_valid", mem_to_wb_valid, 1'b0);
        chk("rst2_ready", mem_to_exe_ready, 1'b1);
        chk("rst2_bus", mem_to_wb_bus, '0);
        chk("rst2_fwd", {mem_fwd_valid, mem_fwd_addr, mem_fwd_data}, '0);
        chk("rst2_mis", mem_misalign, 1'b0);

        wb_to_mem_ready  = 1'b1;
        exe_to_mem_bus   = mk(1'b1, 5'd4, 32'hABCD, 3'd0);
        exe_to_mem_valid = 1'b1;
        tick();
        exe_to_mem_valid = 1'b0;
        #1;
        chk("post_rst_bus", mem_to_wb_bus, wb(1'b1, 5'd4, 32'hABCD));
        chk("post_rst_fwd", mem_fwd_valid, 1'b1);
        tick();
        chk("post_rst_drain", mem_to_wb_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
